// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and FSM state type for the pwm8b generator/capture pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

   localparam int PWM_W       = 8;
   localparam int PWM_PERIOD  = 2**PWM_W;
   localparam int PWM_TIMEOUT = 2 * PWM_PERIOD;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      HIGH   = 2'd2,
      LOW    = 2'd3
   } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: synchronises the async PWM line, optionally deglitches it, and flags rise/fall.
// Latency: SYNC clk to lvl/rise/fall; +2 clk when PWM8B_CAPTURE_FILTER_EN is defined.
// Backpressure: none; edge flags are single-cycle and always produced.
module pwm_in_sync
   import pwm_pkg::*;
#(
   parameter int SYNC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic rise,
   output logic fall,
   output logic lvl
);

   logic [SYNC-1:0] sync_q;
   logic            prev_q;
   logic            lvl_c;

   // Metastability chain; the oldest stage is the first usable sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC-2:0], pwm_in};
   end

`ifdef PWM8B_CAPTURE_FILTER_EN
   logic [2:0] flt_q;

   // Three-sample window; a lone 1-clk pulse never wins the majority vote.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flt_q <= '0;
      else        flt_q <= {flt_q[1:0], sync_q[SYNC-1]};
   end

   assign lvl_c = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
`else
   assign lvl_c = sync_q[SYNC-1];
`endif

   // Previous level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= lvl_c;
   end

   assign lvl  = lvl_c;
   assign rise = lvl_c & ~prev_q;
   assign fall = ~lvl_c & prev_q;

endmodule

// File: rtl/pwm8b_capture.sv
// pwm8b_capture: measures PWM high time/period and recovers the W-bit duty (optional deglitch: PWM8B_CAPTURE_FILTER_EN).
// Latency: valid SYNC+1 clk after the closing rising edge (SYNC+3 with the filter enabled).
// Backpressure: none; value_out/valid is a one-cycle strobe the consumer must take when offered.
module pwm8b_capture
   import pwm_pkg::*;
#(
   parameter int W    = PWM_W,
   parameter int TOL  = 2,
   parameter int SYNC = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         pwm_in,
   output logic [W-1:0] value_out,
   output logic         valid,
   output logic         locked,
   output logic         err
);

   localparam int CW = W + 2;
   localparam int PW = CW + 1;
   localparam logic [PW-1:0] PER_MIN  = PW'(2**W - TOL);
   localparam logic [PW-1:0] PER_MAX  = PW'(2**W + TOL);
   localparam logic [CW-1:0] DUTY_MAX = CW'(2**W - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(2 * 2**W - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] hi_cnt, lo_cnt, to_cnt;
   logic [PW-1:0] per;
   logic          rise, fall, lvl;
   logic          per_ok, timeout;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   pwm_in_sync #(.SYNC(SYNC)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .rise   (rise),
      .fall   (fall),
      .lvl    (lvl)
   );

   assign per    = {1'b0, hi_cnt} + {1'b0, lo_cnt};
   assign per_ok = (per >= PER_MIN) && (per <= PER_MAX);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; a static line past the timeout resynchronises to its current level.
   always_comb begin
      state_d = state_q;
      timeout = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = SEARCH;
            SEARCH:  if (rise) state_d = HIGH;
            HIGH:    if (fall) state_d = LOW;
            LOW:     if (rise) state_d = HIGH;
            default: state_d = IDLE;
         endcase
         if (state_q != IDLE && !rise && !fall && to_cnt == TO_LAST) begin
            timeout = 1'b1;
            state_d = lvl ? HIGH : SEARCH;
         end
      end
   end

   // Counters, period check and output registers; the rise cycle counts as high, the fall cycle as low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_cnt    <= '0;
         lo_cnt    <= '0;
         to_cnt    <= '0;
         value_out <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!en || state_q == IDLE) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
            to_cnt <= '0;
            if (!en) err <= 1'b0;
         end else if (timeout) begin
            hi_cnt    <= '0;
            lo_cnt    <= '0;
            to_cnt    <= '0;
            value_out <= {W{lvl}};
            valid     <= 1'b1;
            locked    <= 1'b1;
         end else begin
            to_cnt <= (rise || fall) ? '0 : to_cnt + 1'b1;
            case (state_q)
               SEARCH: begin
                  if (rise) begin
                     hi_cnt <= CW'(1);
                     lo_cnt <= '0;
                  end
               end
               HIGH: begin
                  if (fall) lo_cnt <= CW'(1);
                  else      hi_cnt <= sat_inc(hi_cnt);
               end
               LOW: begin
                  if (rise) begin
                     valid  <= 1'b1;
                     hi_cnt <= CW'(1);
                     lo_cnt <= '0;
                     if (per_ok) begin
                        locked    <= 1'b1;
                        value_out <= (hi_cnt > DUTY_MAX) ? {W{1'b1}} : hi_cnt[W-1:0];
                     end else begin
                        locked <= 1'b0;
                        err    <= 1'b1;
                     end
                  end else begin
                     lo_cnt <= sat_inc(lo_cnt);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm8b_capture.sv
// tb_pwm8b_capture: directed stimulus for pwm8b_capture with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm8b_capture;

   localparam int SYNC = 2;
`ifdef PWM8B_CAPTURE_FILTER_EN
   localparam int LAT  = SYNC + 3;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = SYNC + 1;
   localparam bit FILT = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       en     = 1'b0;
   logic       pwm_in = 1'b0;
   logic [7:0] value_out;
   logic       valid, locked, err;

   int         n_cmp     = 0;
   int         n_bad     = 0;
   int         cyc       = 0;
   int         vcount    = 0;
   int         last_vcyc = 0;
   int         prev_vcyc = 0;
   int         last_lat  = -1;
   int         base      = 0;
   logic [7:0] last_val  = '0;

   pwm8b_capture #(.W(8), .TOL(2), .SYNC(SYNC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pwm_in    (pwm_in),
      .value_out (value_out),
      .valid     (valid),
      .locked    (locked),
      .err       (err)
   );

   always #5 clk = ~clk;

   // One clock; sample outputs 1 time unit after the edge and log valid strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
         vcount++;
         prev_vcyc = last_vcyc;
         last_vcyc = cyc;
         last_val  = value_out;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) tick();
   endtask

   // One PWM period starting with the rising edge; records ticks from rise to valid.
   task automatic period(input int hi, input int lo);
      int v0;
      v0 = vcount;
      last_lat = -1;
      pwm_in = 1'b1;
      for (int k = 1; k <= hi; k++) begin
         tick();
         if (vcount != v0 && last_lat < 0) last_lat = k;
      end
      pwm_in = 1'b0;
      repeat (lo) tick();
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_value", value_out, 0);
      check("rst_valid", valid, 0);
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);

      // Duty 10, nominal period
      rst_n = 1'b1;
      en    = 1'b1;
      hold(1'b0, 20);
      base = vcount;
      period(10, 246);
      period(10, 246);
      period(10, 246);
      check("d10_nvalid", vcount - base, 2);
      check("d10_value", last_val, 10);
      check("d10_locked", locked, 1);
      check("d10_err", err, 0);
      check("d10_interval", last_vcyc - prev_vcyc, 256);
      check("d10_latency", last_lat, LAT);

      // Duty change 10 -> 200
      base = vcount;
      period(200, 56);
      period(200, 56);
      check("d200_nvalid", vcount - base, 2);
      check("d200_value", last_val, 200);
      check("d200_err", err, 0);
      check("d200_locked", locked, 1);

      // 300-clk period: err, unlocked, value held
      base = vcount;
      period(100, 200);
      period(100, 200);
      check("p300_nvalid", vcount - base, 2);
      check("p300_err", err, 1);
      check("p300_locked", locked, 0);
      check("p300_value", value_out, 200);
      check("p300_strobe_value", last_val, 200);

      // Good periods again: err stays sticky
      period(10, 246);
      period(10, 246);
      check("sticky_err", err, 1);
      check("relock_locked", locked, 1);
      check("relock_value", value_out, 10);

      // en=0 clears err, holds value
      en = 1'b0;
      repeat (3) tick();
      check("dis_err", err, 0);
      check("dis_value", value_out, 10);
      check("dis_valid", valid, 0);

      // Tolerance boundaries: 258 and 254 accepted, 259 rejected
      en = 1'b1;
      hold(1'b0, 20);
      period(50, 208);
      period(60, 194);
      check("tol258_value", last_val, 50);
      check("tol258_locked", locked, 1);
      check("tol258_err", err, 0);
      period(70, 189);
      check("tol254_value", last_val, 60);
      check("tol254_locked", locked, 1);
      check("tol254_err", err, 0);
      period(10, 246);
      check("tol259_err", err, 1);
      check("tol259_locked", locked, 0);
      check("tol259_value", value_out, 60);

      // Line stuck low: timeout every 512 clk with 0
      base = vcount;
      hold(1'b0, 1100);
      check("low_nvalid", vcount - base, 2);
      check("low_value", last_val, 0);
      check("low_locked", locked, 1);
      check("low_interval", last_vcyc - prev_vcyc, 512);
      check("low_err_sticky", err, 1);

      // Line stuck high: timeout every 512 clk with 255
      base = vcount;
      hold(1'b1, 1100);
      check("high_nvalid", vcount - base, 2);
      check("high_value", last_val, 255);
      check("high_interval", last_vcyc - prev_vcyc, 512);
      check("high_locked", locked, 1);

      // Reset at cycle 130 of a period
      hold(1'b0, 30);
      hold(1'b1, 100);
      hold(1'b0, 30);
      check("prerst_value", value_out, 255);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_value", value_out, 0);
      check("midrst_valid", valid, 0);
      check("midrst_locked", locked, 0);
      check("midrst_err", err, 0);
      tick();
      rst_n = 1'b1;
      en    = 1'b1;
      hold(1'b0, 126);
      base = vcount;
      period(10, 246);
      check("postrst_first_rise", vcount - base, 0);
      period(10, 246);
      check("postrst_second_rise", vcount - base, 1);
      check("postrst_value", last_val, 10);
      check("postrst_locked", locked, 1);

      // One-clock spike inside the low phase
      period(10, 100);
      hold(1'b1, 1);
      hold(1'b0, 145);
      hold(1'b1, 12);
      check("spike_err", err, FILT ? 0 : 1);
      check("spike_locked", locked, FILT ? 1 : 0);
      check("spike_value", value_out, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
